// File: rtl/reward_scan_engine.sv
// Reward scan engine: scans the neighbour table for the chosen action node and emits a saturating reward packet.
// Optional macro REWARD_STATS_EN adds reward_total / scan_count statistics outputs.
module reward_scan_engine #(
  parameter int WORD_WIDTH      = 16,
  parameter int NUM_NEIGHBORS   = 8,
  parameter int TABLE_BASE      = 0,
  parameter int MEM_RD_LAT      = 1,
  parameter int HOP_WEIGHT      = 2,
  parameter int BEST_BONUS      = 16,
  parameter int CLUSTER_PENALTY = 8
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [WORD_WIDTH-1:0]   _action,
  input  logic [WORD_WIDTH-1:0]   _besthop,
  input  logic [WORD_WIDTH-1:0]   MY_NODE_ID,
  input  logic [WORD_WIDTH-1:0]   MY_CLUSTER_ID,
  input  logic                    done_prev,
  output logic [WORD_WIDTH-1:0]   address,
  output logic                    wr_en,
  input  logic [WORD_WIDTH-1:0]   mem_data_out,
  output logic [5*WORD_WIDTH-1:0] reward_data_out,
  output logic                    done_reward,
  output logic                    busy,
  output logic                    miss
`ifdef REWARD_STATS_EN
  ,
  output logic [2*WORD_WIDTH-1:0] reward_total,
  output logic [WORD_WIDTH-1:0]   scan_count
`endif
);

  localparam int W = WORD_WIDTH;
  localparam logic [8:0]  LAST_K   = 9'(NUM_NEIGHBORS - 1);
  localparam logic [15:0] CAP_WAIT = 16'(MEM_RD_LAT);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RD_ID  = 3'd1,
    RD_CL  = 3'd2,
    RD_HOP = 3'd3,
    RD_EN  = 3'd4,
    CALC   = 3'd5,
    DONE   = 3'd6
  } state_t;

  state_t           state_q, state_d;
  logic             prev_q;
  logic [W-1:0]     act_q, act_d, best_q, best_d, node_q, node_d, mycl_q, mycl_d;
  logic [W-1:0]     addr_q, addr_d;
  logic [15:0]      wait_q, wait_d;
  logic [8:0]       k_q, k_d;
  logic [W-1:0]     cl_q, cl_d, hop_q, hop_d, en_q, en_d, rew_q, rew_d;
  logic             scan_miss_q, scan_miss_d;
  logic [5*W-1:0]   pkt_q, pkt_d;
  logic             done_q, done_d, busy_q, busy_d, miss_q, miss_d;
  logic             start_s, capture_s;
  logic [2*W-1:0]   prod_s;
  logic [W-1:0]     r1_s, r2_s, r3_s;
  logic [W:0]       sum_s;
`ifdef REWARD_STATS_EN
  logic [2*W-1:0]   total_q, total_d;
  logic [W-1:0]     count_q, count_d;
  logic [2*W:0]     total_sum_s;
`endif

  assign start_s   = (state_q == IDLE) && done_prev && !prev_q;
  assign capture_s = (wait_q == CAP_WAIT);

  // Saturating reward from the captured entry fields.
  always_comb begin
    prod_s = {{W{1'b0}}, hop_q} * (2*W)'(HOP_WEIGHT);
    r1_s   = ({{W{1'b0}}, en_q} > prod_s) ? (en_q - prod_s[W-1:0]) : {W{1'b0}};
    sum_s  = {1'b0, r1_s} + (W+1)'(BEST_BONUS);
    r2_s   = (act_q == best_q) ? (sum_s[W] ? {W{1'b1}} : sum_s[W-1:0]) : r1_s;
    r3_s   = (cl_q != mycl_q)
             ? ((r2_s > W'(CLUSTER_PENALTY)) ? (r2_s - W'(CLUSTER_PENALTY)) : {W{1'b0}})
             : r2_s;
  end

  // Next-state and datapath next values.
  always_comb begin
    state_d     = state_q;
    act_d       = act_q;
    best_d      = best_q;
    node_d      = node_q;
    mycl_d      = mycl_q;
    addr_d      = addr_q;
    wait_d      = wait_q;
    k_d         = k_q;
    cl_d        = cl_q;
    hop_d       = hop_q;
    en_d        = en_q;
    rew_d       = rew_q;
    scan_miss_d = scan_miss_q;
    pkt_d       = pkt_q;
    miss_d      = miss_q;
    done_d      = 1'b0;
    busy_d      = (state_q != IDLE) || start_s;
`ifdef REWARD_STATS_EN
    total_sum_s = {1'b0, total_q} + {{(W+1){1'b0}}, rew_q};
    total_d     = total_q;
    count_d     = count_q;
`endif
    case (state_q)
      IDLE: begin
        if (start_s) begin
          act_d       = _action;
          best_d      = _besthop;
          node_d      = MY_NODE_ID;
          mycl_d      = MY_CLUSTER_ID;
          addr_d      = W'(TABLE_BASE);
          wait_d      = 16'd0;
          k_d         = 9'd0;
          scan_miss_d = 1'b0;
          state_d     = RD_ID;
        end else begin
          state_d = IDLE;
        end
      end
      RD_ID: begin
        if (!capture_s) begin
          wait_d = wait_q + 16'd1;
        end else if (mem_data_out == act_q) begin
          addr_d  = addr_q + W'(1);
          wait_d  = 16'd0;
          state_d = RD_CL;
        end else if (k_q == LAST_K) begin
          scan_miss_d = 1'b1;
          hop_d       = {W{1'b1}};
          state_d     = CALC;
        end else begin
          k_d    = k_q + 9'd1;
          addr_d = addr_q + W'(4);
          wait_d = 16'd0;
        end
      end
      RD_CL: begin
        if (capture_s) begin
          cl_d    = mem_data_out;
          addr_d  = addr_q + W'(1);
          wait_d  = 16'd0;
          state_d = RD_HOP;
        end else begin
          wait_d = wait_q + 16'd1;
        end
      end
      RD_HOP: begin
        if (capture_s) begin
          hop_d   = mem_data_out;
          addr_d  = addr_q + W'(1);
          wait_d  = 16'd0;
          state_d = RD_EN;
        end else begin
          wait_d = wait_q + 16'd1;
        end
      end
      RD_EN: begin
        if (capture_s) begin
          en_d    = mem_data_out;
          state_d = CALC;
        end else begin
          wait_d = wait_q + 16'd1;
        end
      end
      CALC: begin
        rew_d   = scan_miss_q ? {W{1'b0}} : r3_s;
        state_d = DONE;
      end
      DONE: begin
        done_d  = 1'b1;
        pkt_d   = {node_q, mycl_q, act_q, hop_q, rew_q};
        miss_d  = scan_miss_q;
        state_d = IDLE;
`ifdef REWARD_STATS_EN
        total_d = total_sum_s[2*W] ? {(2*W){1'b1}} : total_sum_s[2*W-1:0];
        count_d = count_q + W'(1);
`endif
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      prev_q      <= 1'b0;
      act_q       <= '0;
      best_q      <= '0;
      node_q      <= '0;
      mycl_q      <= '0;
      addr_q      <= '0;
      wait_q      <= '0;
      k_q         <= '0;
      cl_q        <= '0;
      hop_q       <= '0;
      en_q        <= '0;
      rew_q       <= '0;
      scan_miss_q <= 1'b0;
      pkt_q       <= '0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
      miss_q      <= 1'b0;
`ifdef REWARD_STATS_EN
      total_q     <= '0;
      count_q     <= '0;
`endif
    end else begin
      state_q     <= state_d;
      prev_q      <= done_prev;
      act_q       <= act_d;
      best_q      <= best_d;
      node_q      <= node_d;
      mycl_q      <= mycl_d;
      addr_q      <= addr_d;
      wait_q      <= wait_d;
      k_q         <= k_d;
      cl_q        <= cl_d;
      hop_q       <= hop_d;
      en_q        <= en_d;
      rew_q       <= rew_d;
      scan_miss_q <= scan_miss_d;
      pkt_q       <= pkt_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
      miss_q      <= miss_d;
`ifdef REWARD_STATS_EN
      total_q     <= total_d;
      count_q     <= count_d;
`endif
    end
  end

  assign address         = addr_q;
  assign wr_en           = 1'b0;
  assign reward_data_out = pkt_q;
  assign done_reward     = done_q;
  assign busy            = busy_q;
  assign miss            = miss_q;
`ifdef REWARD_STATS_EN
  assign reward_total    = total_q;
  assign scan_count      = count_q;
`endif

endmodule

// File: tb/tb_reward_scan_engine.sv
// Self-checking bench for reward_scan_engine: table of directed scans plus hand-written corner sequences.
// Honours REWARD_STATS_EN when defined.
module tb_reward_scan_engine;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] _action = 16'd0, _besthop = 16'd0, MY_NODE_ID = 16'd0, MY_CLUSTER_ID = 16'd0;
  logic        done_prev = 1'b0;
  logic [15:0] address;
  logic        wr_en;
  logic [15:0] mem_data_out;
  logic [79:0] reward_data_out;
  logic        done_reward, busy, miss;
`ifdef REWARD_STATS_EN
  logic [31:0] reward_total;
  logic [15:0] scan_count;
  logic [31:0] m_total = 32'd0;
  logic [15:0] m_count = 16'd0;
`endif

  logic [15:0] mem [0:255];
  logic [15:0] mem_rd = 16'd0;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  // Memory with one cycle of read latency.
  always @(posedge clock) mem_rd <= mem[address[7:0]];
  assign mem_data_out = mem_rd;

  reward_scan_engine dut (
    .clock(clock), .reset(reset),
    ._action(_action), ._besthop(_besthop),
    .MY_NODE_ID(MY_NODE_ID), .MY_CLUSTER_ID(MY_CLUSTER_ID),
    .done_prev(done_prev), .address(address), .wr_en(wr_en),
    .mem_data_out(mem_data_out), .reward_data_out(reward_data_out),
    .done_reward(done_reward), .busy(busy), .miss(miss)
`ifdef REWARD_STATS_EN
    , .reward_total(reward_total), .scan_count(scan_count)
`endif
  );

  typedef struct {
    logic [15:0] act, best, node, mycl, hop, rew;
    logic        miss;
    int          lat;
  } vec_t;

  vec_t vt [9];

  task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  task automatic set_entry(input int k, input logic [15:0] id, cl, hop, en);
    mem[4*k]   = id;
    mem[4*k+1] = cl;
    mem[4*k+2] = hop;
    mem[4*k+3] = en;
  endtask

  task automatic run_scan(input vec_t v);
    logic [79:0] pkt;
    int lat;
    pkt = {v.node, v.mycl, v.act, v.hop, v.rew};
    @(negedge clock);
    _action = v.act; _besthop = v.best; MY_NODE_ID = v.node; MY_CLUSTER_ID = v.mycl;
    done_prev = 1'b1;
    @(posedge clock); #1;
    done_prev = 1'b0;
    chk("busy_after_start", 80'(busy), 80'd1);
    lat = 0;
    for (int e = 1; e <= 40 && lat == 0; e++) begin
      @(posedge clock); #1;
      if (done_reward) lat = e;
    end
    chk("latency", 80'(lat), 80'(v.lat));
    chk("packet", reward_data_out, pkt);
    chk("miss", 80'(miss), 80'(v.miss));
    chk("busy_at_done", 80'(busy), 80'd1);
    chk("wr_en", 80'(wr_en), 80'd0);
    chk("addr_in_table", 80'(address <= 16'd31), 80'd1);
    @(posedge clock); #1;
    chk("done_one_cycle", 80'(done_reward), 80'd0);
    chk("busy_after_done", 80'(busy), 80'd0);
    chk("packet_held", reward_data_out, pkt);
    chk("miss_held", 80'(miss), 80'(v.miss));
`ifdef REWARD_STATS_EN
    m_total = m_total + 32'(v.rew);
    m_count = m_count + 16'd1;
`endif
  endtask

  initial begin
    logic [79:0] pkt0;
    int pulses, first_lat;

    for (int i = 0; i < 256; i++) mem[i] = 16'd0;
    set_entry(0, 16'd5,  16'd1, 16'd3,  16'd100);
    set_entry(1, 16'd12, 16'd1, 16'd2,  16'd50);
    set_entry(2, 16'd9,  16'd2, 16'd10, 16'd15);
    set_entry(3, 16'd20, 16'd3, 16'd4,  16'd40);
    set_entry(4, 16'd33, 16'd1, 16'd0,  16'hFFF8);
    set_entry(5, 16'd40, 16'd2, 16'd1,  16'd30);
    set_entry(6, 16'd5,  16'd1, 16'd0,  16'd0);
    set_entry(7, 16'd60, 16'd1, 16'd5,  16'd9);

    //              act     best    node      mycl   hop       reward    miss lat
    vt[0] = '{16'd5,  16'd5,  16'h00A0, 16'd1, 16'd3,    16'h006E, 1'b0, 10};
    vt[1] = '{16'd9,  16'd5,  16'h00A1, 16'd1, 16'd10,   16'h0000, 1'b0, 14};
    vt[2] = '{16'd77, 16'd5,  16'h00A2, 16'd1, 16'hFFFF, 16'h0000, 1'b1, 18};
    vt[3] = '{16'd33, 16'd33, 16'h00A3, 16'd1, 16'd0,    16'hFFFF, 1'b0, 18};
    vt[4] = '{16'd20, 16'd5,  16'h00A4, 16'd1, 16'd4,    16'd24,   1'b0, 16};
    vt[5] = '{16'd40, 16'd40, 16'h00A5, 16'd1, 16'd1,    16'd36,   1'b0, 20};
    vt[6] = '{16'd60, 16'd5,  16'h00A6, 16'd1, 16'd5,    16'd0,    1'b0, 24};
    vt[7] = '{16'd12, 16'd12, 16'h00A7, 16'd2, 16'd2,    16'd54,   1'b0, 12};
    vt[8] = '{16'd5,  16'd7,  16'h00A8, 16'd3, 16'd3,    16'd86,   1'b0, 10};

    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    chk("rst_address", 80'(address), 80'd0);
    chk("rst_wr_en", 80'(wr_en), 80'd0);
    chk("rst_packet", reward_data_out, 80'd0);
    chk("rst_done", 80'(done_reward), 80'd0);
    chk("rst_busy", 80'(busy), 80'd0);
    chk("rst_miss", 80'(miss), 80'd0);

    for (int i = 0; i < 9; i++) run_scan(vt[i]);
`ifdef REWARD_STATS_EN
    chk("stats_total", 80'(reward_total), 80'(m_total));
    chk("stats_count", 80'(scan_count), 80'(m_count));
`endif

    // A second start edge during a scan is dropped; inputs stay latched.
    pkt0 = {vt[0].node, vt[0].mycl, vt[0].act, vt[0].hop, vt[0].rew};
    @(negedge clock);
    _action = vt[0].act; _besthop = vt[0].best; MY_NODE_ID = vt[0].node; MY_CLUSTER_ID = vt[0].mycl;
    done_prev = 1'b1;
    @(posedge clock); #1 done_prev = 1'b0;
    repeat (3) @(posedge clock);
    #1 begin done_prev = 1'b1; _action = 16'd9; end
    @(posedge clock); #1 done_prev = 1'b0;
    pulses = 0; first_lat = 0;
    for (int e = 5; e <= 34; e++) begin
      @(posedge clock); #1;
      if (done_reward) begin
        pulses++;
        if (first_lat == 0) first_lat = e;
        chk("ignored_edge_packet", reward_data_out, pkt0);
      end
    end
    chk("ignored_edge_pulses", 80'(pulses), 80'd1);
    chk("ignored_edge_latency", 80'(first_lat), 80'd10);
`ifdef REWARD_STATS_EN
    m_total = m_total + 32'(vt[0].rew);
    m_count = m_count + 16'd1;
`endif
    run_scan(vt[7]);
    run_scan(vt[2]);

    // Reset in the middle of a scan aborts it.
    @(negedge clock);
    _action = vt[0].act; _besthop = vt[0].best; MY_NODE_ID = vt[0].node; MY_CLUSTER_ID = vt[0].mycl;
    done_prev = 1'b1;
    @(posedge clock); #1 done_prev = 1'b0;
    repeat (4) @(posedge clock);
    #1 reset = 1'b1;
    @(posedge clock); #1 reset = 1'b0;
    chk("midrst_busy", 80'(busy), 80'd0);
    chk("midrst_packet", reward_data_out, 80'd0);
    chk("midrst_miss", 80'(miss), 80'd0);
    chk("midrst_address", 80'(address), 80'd0);
`ifdef REWARD_STATS_EN
    chk("midrst_total", 80'(reward_total), 80'd0);
    chk("midrst_count", 80'(scan_count), 80'd0);
    m_total = 32'd0;
    m_count = 16'd0;
`endif
    pulses = 0;
    for (int e = 0; e < 25; e++) begin
      @(posedge clock); #1;
      if (done_reward) pulses++;
    end
    chk("midrst_no_done", 80'(pulses), 80'd0);
    run_scan(vt[1]);

    // Start edge coincident with reset is ignored.
    @(negedge clock);
    reset = 1'b1; done_prev = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0; done_prev = 1'b0;
    chk("rst_start_busy0", 80'(busy), 80'd0);
    @(posedge clock); #1;
    chk("rst_start_busy1", 80'(busy), 80'd0);
    run_scan(vt[4]);
`ifdef REWARD_STATS_EN
    chk("stats_total_end", 80'(reward_total), 80'(m_total));
    chk("stats_count_end", 80'(scan_count), 80'(m_count));
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
